fb_scanout: RTL and testbench

- Reads the 64x32 monochrome framebuffer at 0x100-0x1FF through the shared memory read handshake.
- Streams the frame out one pixel at a time over a valid/ready interface.
- Display drivers (OLED/LCD serialisers, VGA line buffers) sit downstream.
- It is the read-side consumer of the framebuffer that the sprite draw engine writes; the two never run concurrently (CPU/arbiter sequences them).

---
 rtl/fb_scanout.sv | 156 +++++++++++++++
 tb/tb_fb_scanout.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: reads the 64x32 mono framebuffer byte by byte and streams pixels MSB first.
// Define FB_SCANOUT_PREFETCH_EN to add a one-byte prefetch buffer for gap-free streaming.
module fb_scanout #(
    parameter logic [11:0] FB_BASE     = 12'h100,
    parameter int unsigned WIDTH_BYTES = 8,
    parameter int unsigned HEIGHT      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol
);
    localparam logic [7:0] LAST_BYTE = 8'(WIDTH_BYTES * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_cnt, byte_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       rd_req;
    logic [7:0] rd_off;
    logic       pix_fire;
    logic       last_bit;
    logic       last_byte;
`ifdef FB_SCANOUT_PREFETCH_EN
    logic       pf_valid, pf_valid_nxt;
    logic [7:0] pf_data, pf_data_nxt;
`endif

    assign pix_fire  = pix_valid & pix_ready;
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == LAST_BYTE);

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        rd_req       = 1'b0;
        rd_off       = byte_cnt;
        pix_valid    = 1'b0;
        frame_done   = 1'b0;
`ifdef FB_SCANOUT_PREFETCH_EN
        pf_valid_nxt = pf_valid;
        pf_data_nxt  = pf_data;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = FETCH;
                    byte_cnt_nxt = '0;
                end
            end
            FETCH: begin
                rd_req = 1'b1;
                if (mem_read_ack) begin
                    shreg_nxt   = mem_read_byte;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                pix_valid = 1'b1;
`ifdef FB_SCANOUT_PREFETCH_EN
                if (!pf_valid && !last_byte) begin
                    rd_req = 1'b1;
                    rd_off = byte_cnt + 8'd1;
                    if (mem_read_ack) begin
                        pf_valid_nxt = 1'b1;
                        pf_data_nxt  = mem_read_byte;
                    end
                end
`endif
                if (pix_fire) begin
                    shreg_nxt   = {shreg[6:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (last_bit) begin
                        if (last_byte) begin
                            state_nxt = DONE;
                        end else begin
                            byte_cnt_nxt = byte_cnt + 8'd1;
`ifdef FB_SCANOUT_PREFETCH_EN
                            // An ack landing on the final bit is forwarded straight into the shifter.
                            if (pf_valid) begin
                                shreg_nxt    = pf_data;
                                pf_valid_nxt = 1'b0;
                            end else if (rd_req && mem_read_ack) begin
                                shreg_nxt    = mem_read_byte;
                                pf_valid_nxt = 1'b0;
                            end else begin
                                state_nxt = FETCH;
                            end
`else
                            state_nxt = FETCH;
`endif
                        end
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign mem_read     = rd_req & ~mem_read_ack;
    assign mem_read_idx = rd_req ? (FB_BASE + {4'b0000, rd_off}) : '0;
    assign pix_data     = shreg[7];
    assign pix_x        = {byte_cnt[2:0], bit_cnt};
    assign pix_y        = byte_cnt[7:3];
    assign pix_sof      = pix_valid & (byte_cnt == 8'd0) & (bit_cnt == 3'd0);
    assign pix_eol      = pix_valid & (byte_cnt[2:0] == 3'd7) & last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
        end
    end

`ifdef FB_SCANOUT_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_data  <= '0;
        end else begin
            pf_valid <= pf_valid_nxt;
            pf_data  <= pf_data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: expected pixels/addresses are queued at frame start, a monitor pops them.
module tb_fb_scanout;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, frame_done, mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte = '0;
    logic        mem_read_ack = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_data;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;
    logic        pix_sof, pix_eol;

    fb_scanout #(.FB_BASE(12'h100), .WIDTH_BYTES(8), .HEIGHT(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx), .mem_read_byte(mem_read_byte),
        .mem_read_ack(mem_read_ack), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    always #5 clk = ~clk;

`ifdef FB_SCANOUT_PREFETCH_EN
    localparam int GAP_ACK1 = 0;
    localparam int GAP_ACK5 = 0;
`else
    localparam int GAP_ACK1 = 510;
    localparam int GAP_ACK5 = 1530;
`endif

    typedef struct packed {
        logic       d;
        logic [5:0] x;
        logic [4:0] y;
        logic       sof;
        logic       eol;
    } pix_t;

    pix_t        exp_pix[$];
    logic [11:0] exp_addr[$];
    logic [10:0] lit[$];
    logic [7:0]  mem[0:255];

    int checks = 0;
    int failures = 0;
    int ack_delay = 1;
    int ready_mode = 0;
    int pix_cnt = 0;
    int eol_cnt = 0;
    int done_cnt = 0;
    int gap_cnt = 0;
    bit in_frame = 1'b0;
    int wait_cnt = 0;
    logic [11:0] rsp_addr;
    logic [11:0] rsp_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic push_frame();
        pix_t p;
        logic [7:0] bv;
        for (int b = 0; b < 256; b++) begin
            exp_addr.push_back(12'h100 + 12'(b));
            bv = mem[b];
            for (int i = 0; i < 8; i++) begin
                p.d   = bv[7 - i];
                p.x   = 6'((b % 8) * 8 + i);
                p.y   = 5'(b / 8);
                p.sof = (b == 0) && (i == 0);
                p.eol = ((b % 8) == 7) && (i == 7);
                exp_pix.push_back(p);
            end
        end
    endtask

    // Memory responder: acks ack_delay cycles after the request is first seen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_read) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    rsp_addr = mem_read_idx;
                    @(posedge clk);
                    #1;
                    mem_read_ack  = 1'b1;
                    mem_read_byte = mem[rsp_addr[7:0]];
                    if (rst_n) begin
                        if (exp_addr.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL addr_unexpected actual=%0h required=none", rsp_addr);
                        end else begin
                            rsp_exp = exp_addr.pop_front();
                            check("mem_read_idx", 32'(rsp_addr), 32'(rsp_exp));
                        end
                    end
                    @(posedge clk);
                    #1;
                    mem_read_ack = 1'b0;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
        end
    end

    // Monitor: pixel scoreboard, hold-while-stalled and read-handshake rules.
    initial begin
        bit          prev_stall = 1'b0;
        bit          prev_rd = 1'b0;
        logic [12:0] prev_pix = '0;
        logic [11:0] prev_idx = '0;
        pix_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_rd = 1'b0;
            end else begin
                if (frame_done) done_cnt++;
                if (mem_read_ack) check("mem_read_low_in_ack", 32'(mem_read), 32'd0);
                if (prev_rd) begin
                    check("mem_read_hold", 32'(mem_read | mem_read_ack), 32'd1);
                    check("mem_read_idx_hold", 32'(mem_read_idx), 32'(prev_idx));
                end
                if (prev_stall)
                    check("pix_hold", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'(prev_pix));
                if (in_frame && !pix_valid) gap_cnt++;
                if (pix_valid && pix_ready) begin
                    pix_cnt++;
                    if (pix_eol) eol_cnt++;
                    if (pix_data) lit.push_back({pix_y, pix_x});
                    if (exp_pix.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pix_unexpected actual=(%0d,%0d) required=none", pix_x, pix_y);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pix", 32'({pix_data, pix_x, pix_y, pix_sof, pix_eol}), 32'(e));
                    end
                    if (pix_sof) in_frame = 1'b1;
                    if (pix_x == 6'd63 && pix_y == 5'd31) in_frame = 1'b0;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_pix   = {1'b1, pix_data, pix_x, pix_y};
                prev_rd    = mem_read;
                prev_idx   = mem_read_idx;
            end
        end
    end

    task automatic pulse_start_and_check();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        check("start_to_mem_read", 32'(mem_read), 32'd1);
        check("first_idx", 32'(mem_read_idx), 32'h100);
    endtask

    task automatic run_frame(input bit mid_start, input bit start_at_done);
        int  base_done;
        int  cyc;
        bit  pulsed;
        push_frame();
        lit.delete();
        pix_cnt = 0;
        eol_cnt = 0;
        gap_cnt = 0;
        pulsed = 1'b0;
        base_done = done_cnt;
        pulse_start_and_check();
        cyc = 0;
        while (!frame_done && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (mid_start && !pulsed && pix_cnt >= 1000) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (!frame_done) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=%0d required=frame_done", cyc);
        end
        check("pix_count", 32'(pix_cnt), 32'd2048);
        check("eol_count", 32'(eol_cnt), 32'd32);
        check("exp_pix_drained", 32'(exp_pix.size()), 32'd0);
        check("exp_addr_drained", 32'(exp_addr.size()), 32'd0);
        if (start_at_done) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_done_single", 32'(frame_done), 32'd0);
        check("frame_done_count", 32'(done_cnt - base_done), 32'd1);
    endtask

    initial begin
        int cyc;
        int base_done;
        #12;
        check("rst_outputs", 32'({busy, frame_done, mem_read, pix_valid, pix_sof, pix_eol, pix_data}), 32'd0);
        check("rst_idx_xy", 32'({mem_read_idx, pix_x, pix_y}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single lit pixel at (0,0)
        clear_mem();
        mem[0] = 8'h80;
        ack_delay = 1;
        ready_mode = 0;
        run_frame(1'b0, 1'b0);
        check("t1_lit_count", 32'(lit.size()), 32'd1);
        if (lit.size() > 0) check("t1_lit_pos", 32'(lit[0]), 32'd0);
        check("t1_gap_ack1", 32'(gap_cnt), 32'(GAP_ACK1));

        // Address/order: (1,1) then (63,31)
        clear_mem();
        mem[255] = 8'h01;
        mem[8] = 8'h40;
        run_frame(1'b0, 1'b0);
        check("t2_lit_count", 32'(lit.size()), 32'd2);
        if (lit.size() > 1) begin
            check("t2_lit0", 32'(lit[0]), 32'd65);
            check("t2_lit1", 32'(lit[1]), 32'd2047);
        end

        // Backpressure with a dense pattern
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        ready_mode = 1;
        run_frame(1'b0, 1'b0);

        // Slow memory
        ack_delay = 5;
        ready_mode = 0;
        run_frame(1'b0, 1'b0);
        check("t4_gap_ack5", 32'(gap_cnt), 32'(GAP_ACK5));

        // Start while busy and start coinciding with DONE
        ack_delay = 1;
        ready_mode = 1;
        base_done = done_cnt;
        run_frame(1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_read", 32'(mem_read), 32'd0);
        check("t5_done_total", 32'(done_cnt - base_done), 32'd1);

        // Reset mid-frame at pixel 300
        ready_mode = 0;
        push_frame();
        pix_cnt = 0;
        pulse_start_and_check();
        cyc = 0;
        while (pix_cnt < 300 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_300", 32'(pix_cnt >= 300), 32'd1);
        base_done = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 32'({pix_valid, mem_read, busy, frame_done}), 32'd0);
        exp_pix.delete();
        exp_addr.delete();
        in_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_done", 32'(done_cnt - base_done), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        run_frame(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
